// File: rtl/cla5_pkg.sv
// rtl/cla5_pkg.sv - shared width, word and result types for the 5-bit CLA pipeline
package cla5_pkg;

    localparam int CLA5_W = 5;

    typedef logic [CLA5_W-1:0] cla5_word_t;

    typedef struct packed {
        cla5_word_t sum;
        logic       cout;
        logic       ovf;
    } cla5_res_t;

endpackage

// File: rtl/cla5_core.sv
// rtl/cla5_core.sv - purely combinational 5-bit carry-lookahead adder
module cla5_core
    import cla5_pkg::*;
(
    input  logic [CLA5_W-1:0] a,
    input  logic [CLA5_W-1:0] b,
    input  logic              cin,
    output logic [CLA5_W-1:0] s,
    output logic              cout,
    output logic              c4
);

    logic [CLA5_W-1:0] g;
    logic [CLA5_W-1:0] p;
    logic [CLA5_W:0]   c;

    // Every carry is a flat sum-of-products of g/p/cin, so no carry waits on another.
    always_comb begin
        g = a & b;
        p = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2]) | (p[4] & p[3] & p[2] & g[1])
             | (p[4] & p[3] & p[2] & p[1] & g[0]) | (p[4] & p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[CLA5_W-1:0];
        cout = c[5];
        c4   = c[4];
    end

endmodule

// File: rtl/cla5_pipe_adder.sv
// rtl/cla5_pipe_adder.sv - two-stage valid/ready CLA adder; CLA5_OVF_EN adds the OVF output
module cla5_pipe_adder
    import cla5_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
`ifdef CLA5_OVF_EN
    output logic             COUT,
    output logic             OVF
`else
    output logic             COUT
`endif
);

    generate
        if (WIDTH != CLA5_W) begin : g_width_check
            $error("cla5_pipe_adder: WIDTH must be 5");
        end
    endgenerate

    logic       s1_en;
    logic       s2_en;
    logic       s1_valid_q, s1_valid_d;
    cla5_word_t a_q, a_d;
    cla5_word_t b_q, b_d;
    logic       cin_q, cin_d;
    logic       s2_valid_q, s2_valid_d;
    cla5_word_t s_q, s_d;
    logic       cout_q, cout_d;

    cla5_word_t core_s;
    logic       core_cout;
    logic       core_c4;
    cla5_res_t  res_c;

    cla5_core u_core (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .s    (core_s),
        .cout (core_cout),
        .c4   (core_c4)
    );

    always_comb begin
        res_c.sum  = core_s;
        res_c.cout = core_cout;
        res_c.ovf  = core_c4 ^ core_cout;
    end

    // A stage may advance when it is empty or the stage after it is advancing.
    always_comb begin
        s2_en      = !s2_valid_q || out_ready;
        s1_en      = !s1_valid_q || s2_en;
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        s2_valid_d = s2_valid_q;
        s_d        = s_q;
        cout_d     = cout_q;
        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a_d   = A;
                b_d   = B;
                cin_d = CIN;
            end
        end
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s_d    = res_c.sum;
                cout_d = res_c.cout;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            s2_valid_q <= 1'b0;
            s_q        <= '0;
            cout_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            s2_valid_q <= s2_valid_d;
            s_q        <= s_d;
            cout_q     <= cout_d;
        end
    end

`ifdef CLA5_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (s2_en && s1_valid_q) begin
            ovf_d = res_c.ovf;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = res_c.ovf;
`endif

    assign in_ready  = s1_en;
    assign out_valid = s2_valid_q;
    assign S         = s_q;
    assign COUT      = cout_q;

endmodule

// File: doc/cla5_pipe_adder.md
CLA5_PIPE_ADDER -- requirements
Module: cla5_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 5: operand width; only 5 is supported, and any other value SHALL fail elaboration.
REQ-002 Port CLK, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port RST, input, 1: asynchronous, active-high reset.
REQ-004 Port in_valid, input, 1: the operand set on A/B/CIN is valid.
REQ-005 Port in_ready, output, 1: the block accepts an operand set this cycle.
REQ-006 Ports A and B, input, 5 each: unsigned operands.
REQ-007 Port CIN, input, 1: carry-in.
REQ-008 Port out_valid, output, 1: S, COUT and OVF hold a valid result.
REQ-009 Port out_ready, input, 1: the downstream consumer accepts the result.
REQ-010 Port S, output, 5: sum bits.
REQ-011 Port COUT, output, 1: carry-out of bit 4.
REQ-012 Port OVF, output, 1: signed overflow; present only under CLA5_OVF_EN.

Function
REQ-013 The block SHALL be a two-stage pipeline.
- Stage 1 (input register): captures A, B and CIN into a D-flip-flop bank.
- Stage 2 (result register): registers the CLA sum and carry computed from the stage-1 contents.
REQ-014 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-015 Enables SHALL be as follows.
- s2_en = !s2_valid || out_ready.
- s1_en = !s1_valid || s2_en.
- in_ready = s1_en (combinational; no registered ready).
REQ-016 When s1_en is set, s1_valid SHALL load in_valid, and the operand registers SHALL load only if in_valid is set.
REQ-017 When s2_en is set, s2_valid SHALL load s1_valid, and S/COUT SHALL load only if s1_valid is set.
REQ-018 out_valid SHALL equal s2_valid.
REQ-019 Latency from input transfer to out_valid SHALL be exactly 2 cycles while out_ready=1; sustained throughput SHALL be 1 result per cycle.
REQ-020 Carry logic SHALL be full lookahead, with no ripple dependency.
- g_i = A_i & B_i.
- p_i = A_i ^ B_i.
- c_{i+1} = g_i | p_i & c_i, expanded to two-level form.
- S_i = p_i ^ c_i.
- COUT = c_5.
REQ-021 Arithmetic SHALL be modulo 32: {COUT,S} = A + B + CIN, range 0..63.
REQ-022 Backpressure SHALL be lossless: while out_valid=1 and out_ready=0, S/COUT/OVF SHALL hold stable and no data SHALL be dropped or duplicated.
REQ-023 With both stages full and out_ready=0, in_ready SHALL be 0.
REQ-024 With both stages full, asserting out_ready SHALL set in_ready=1 in the same cycle.
REQ-025 A simultaneous input transfer and output transfer SHALL both complete in that cycle.

Reset
REQ-026 RST=1 SHALL immediately clear s1_valid, s2_valid, S, COUT, OVF and the stage-1 operand registers to 0, independent of CLK.
REQ-027 Results in flight when RST asserts SHALL be discarded.
REQ-028 After RST deasserts, in_ready SHALL be 1 in the first cycle.
REQ-029 An input transfer presented on the first rising CLK edge after RST deasserts SHALL be accepted.

Configuration
REQ-030 Macro CLA5_OVF_EN SHALL control the OVF output.
- Defined: port OVF exists and is registered alongside S, with OVF = c_4 ^ c_5 (two's-complement overflow).
- Undefined: port OVF and its register are absent; all other behaviour is identical.

Structure
REQ-031 Shared package cla5_pkg SHALL hold the following.
- Constant CLA5_W = 5.
- Typedef cla5_word_t (logic [4:0]).
- Typedef cla5_res_t as a struct of sum, cout and ovf.
REQ-032 The lookahead logic SHALL live in a purely combinational sub-module cla5_core.
- Inputs: a, b, cin.
- Outputs: s, cout, c4.
- Instantiated once, between stage 1 and stage 2.

Verification
REQ-033 Single add: A=13, B=9, CIN=0, out_ready=1 -> exactly 2 cycles later out_valid=1, S=22, COUT=0.
REQ-034 Carry wrap: A=31, B=0, CIN=1 -> S=0, COUT=1; with CLA5_OVF_EN, A=15, B=1, CIN=0 -> S=16, OVF=1.
REQ-035 Streaming: 32 back-to-back random sets with out_ready=1 -> one result per cycle, in order, each matching A+B+CIN.
REQ-036 Backpressure: hold out_ready=0 for 4 cycles with in_valid=1.
- in_ready falls after 2 accepts, and S holds stable.
- Releasing out_ready delivers the results in order with no loss or duplication.
REQ-037 Async reset mid-flight: assert RST between clock edges with both stages full.
- out_valid=0 and S=0 without waiting for a clock edge.
- The first post-reset transaction completes normally.
